seq_judge: RTL and testbench

Parametrised successor to the fixed-width answer comparator in the memory-tester game. It captures the random target sequence at round start and checks each punched digit against it as it arrives, aborting on the first wrong digit. It also enforces a per-entry timeout, tracks remaining tries, and reports win/lose/game-over to the level controller. It sits between the RNG/sequence store, the keypad punch logic and the level counter.

---
 rtl/game_pkg.sv | 25 ++
 rtl/seq_judge_if.sv | 40 ++++
 rtl/seq_timeout_timer.sv | 37 +++
 rtl/seq_judge.sv | 174 +++++++++++++++++
 tb/tb_seq_judge.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared types and helpers for the memory-tester game: judge states, default
// digit/sequence sizes used by the RNG and sequence store, and round length.
package game_pkg;

  localparam int DIGIT_W_DEF = 4;
  localparam int MAX_LEN_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_ENTRY,
    ST_WIN_WAIT,
    ST_OVER
  } judge_state_t;

  // Level 0 counts as level 1; long levels saturate at the sequence store depth.
  function automatic int seq_len(input int level, input int base_len, input int max_len);
    int lvl;
    int len;
    lvl = (level < 1) ? 1 : level;
    len = base_len + lvl - 1;
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_judge_if.sv
// Bundle between the game environment (RNG store, keypad, level controller)
// and the sequence judge.
interface seq_judge_if
  import game_pkg::*;
#(
  parameter int DIGIT_W   = DIGIT_W_DEF,
  parameter int MAX_LEN   = MAX_LEN_DEF,
  parameter int MAX_TRIES = 3
);
  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);

  logic                       auth_bit;
  logic                       logout;
  logic                       start;
  logic [3:0]                 level_num;
  logic [MAX_LEN*DIGIT_W-1:0] target_seq;
  logic                       punch;
  logic [DIGIT_W-1:0]         punch_digit;
  logic                       levelupdated;
  logic                       win;
  logic                       loose;
  logic                       game_over;
  logic                       busy;
  logic [IW-1:0]              entry_idx;
  logic [TW-1:0]              tries_left;

  modport master (
    output auth_bit, logout, start, level_num, target_seq,
           punch, punch_digit, levelupdated,
    input  win, loose, game_over, busy, entry_idx, tries_left
  );

  modport slave (
    input  auth_bit, logout, start, level_num, target_seq,
           punch, punch_digit, levelupdated,
    output win, loose, game_over, busy, entry_idx, tries_left
  );

endinterface

// File: rtl/seq_timeout_timer.sv
// Idle-entry watchdog: reloads on load, counts down while enabled and flags
// expiry on the cycle the last allowed idle cycle ends. TIMEOUT_CYC=0 disables it.
module seq_timeout_timer #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clock,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expire
);

  generate
    if (TIMEOUT_CYC == 0) begin : g_disabled
      logic unused_inputs;
      assign unused_inputs = ^{clock, rst, load, enable};
      assign expire = 1'b0;
    end else begin : g_enabled
      localparam int CW = $clog2(TIMEOUT_CYC + 1);
      logic [CW-1:0] count;

      always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
          count <= '0;
        end else if (load) begin
          count <= CW'(TIMEOUT_CYC);
        end else if (enable && count != '0) begin
          count <= count - CW'(1);
        end
      end

      // A count of one means this edge closes the final idle cycle.
      assign expire = enable && (count == CW'(1));
    end
  endgenerate

endmodule

// File: rtl/seq_judge.sv
// Round judge for the memory-tester game: captures the target sequence, checks
// punched digits in order, and tracks timeouts, tries and win/lose/game-over.
module seq_judge
  import game_pkg::*;
#(
  parameter int DIGIT_W     = DIGIT_W_DEF,
  parameter int MAX_LEN     = MAX_LEN_DEF,
  parameter int BASE_LEN    = 3,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1000
) (
  input logic        clock,
  input logic        rst,
  seq_judge_if.slave bus
);

  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);

  judge_state_t               state, state_next;
  logic [MAX_LEN*DIGIT_W-1:0] target_q;
  logic [IW-1:0]              len_q, len_next;
  logic [IW-1:0]              entry_idx_q, entry_idx_next;
  logic [TW-1:0]              tries_q, tries_next;
  logic                       win_q, win_next;
  logic                       loose_q, loose_next;
  logic                       game_over_q;
  logic                       busy_q;
  logic                       capture;
  logic                       fail;
  logic                       timer_load;
  logic                       timer_enable;
  logic                       timer_expire;
  logic [DIGIT_W-1:0]         cur_digit;

  // Selects the digit the player is expected to punch next.
  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (entry_idx_q == IW'(i)) begin
        cur_digit = target_q[i*DIGIT_W +: DIGIT_W];
      end
    end
  end

  assign timer_enable = (state == ST_ENTRY);

  seq_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clock (clock),
    .rst   (rst),
    .load  (timer_load),
    .enable(timer_enable),
    .expire(timer_expire)
  );

  always_comb begin
    state_next     = state;
    len_next       = len_q;
    entry_idx_next = entry_idx_q;
    tries_next     = tries_q;
    win_next       = 1'b0;
    loose_next     = 1'b0;
    capture        = 1'b0;
    timer_load     = 1'b0;
    fail           = 1'b0;

    case (state)
      ST_IDLE: begin
        entry_idx_next = '0;
        tries_next     = TW'(MAX_TRIES);
        if (bus.auth_bit) begin
          state_next = ST_ARMED;
        end
      end

      ST_ARMED: begin
        if (bus.start) begin
          capture        = 1'b1;
          len_next       = IW'(seq_len(int'(bus.level_num), BASE_LEN, MAX_LEN));
          entry_idx_next = '0;
          timer_load     = 1'b1;
          state_next     = ST_ENTRY;
        end
      end

      ST_ENTRY: begin
        // A punch on the expiry edge is judged and the timeout is dropped.
        if (bus.punch) begin
          if (bus.punch_digit == cur_digit) begin
            entry_idx_next = entry_idx_q + IW'(1);
            if (entry_idx_q == len_q - IW'(1)) begin
              win_next   = 1'b1;
              state_next = ST_WIN_WAIT;
            end else begin
              timer_load = 1'b1;
            end
          end else begin
            fail = 1'b1;
          end
        end else if (timer_expire) begin
          fail = 1'b1;
        end

        if (fail) begin
          loose_next = 1'b1;
          tries_next = tries_q - TW'(1);
          state_next = (tries_q == TW'(1)) ? ST_OVER : ST_ARMED;
        end
      end

      ST_WIN_WAIT: begin
        if (bus.levelupdated) begin
          tries_next = TW'(MAX_TRIES);
          state_next = ST_ARMED;
        end
      end

      ST_OVER: begin
        state_next = ST_OVER;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Logout overrides whatever the round decided this cycle.
    if (bus.logout && state != ST_IDLE) begin
      state_next     = ST_IDLE;
      entry_idx_next = '0;
      tries_next     = TW'(MAX_TRIES);
      win_next       = 1'b0;
      loose_next     = 1'b0;
      capture        = 1'b0;
      timer_load     = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      target_q    <= '0;
      len_q       <= '0;
      entry_idx_q <= '0;
      tries_q     <= TW'(MAX_TRIES);
      win_q       <= 1'b0;
      loose_q     <= 1'b0;
      game_over_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_next;
      len_q       <= len_next;
      entry_idx_q <= entry_idx_next;
      tries_q     <= tries_next;
      win_q       <= win_next;
      loose_q     <= loose_next;
      game_over_q <= (state_next == ST_OVER);
      busy_q      <= (state_next == ST_ENTRY);
      if (capture) begin
        target_q <= bus.target_seq;
      end
    end
  end

  assign bus.win        = win_q;
  assign bus.loose      = loose_q;
  assign bus.game_over  = game_over_q;
  assign bus.busy       = busy_q;
  assign bus.entry_idx  = entry_idx_q;
  assign bus.tries_left = tries_q;

endmodule

// File: tb/tb_seq_judge.sv
// Directed bench for seq_judge: hand-computed expectations for wins, wrong
// digits, timeouts, game over, length clamping, async reset and logout.
module tb_seq_judge;

  logic clock = 1'b0;
  logic rst   = 1'b0;
  int   check_count = 0;
  int   fail_count  = 0;

  always #5 clock = ~clock;

  seq_judge_if #(.DIGIT_W(4), .MAX_LEN(16), .MAX_TRIES(3)) bus ();

  seq_judge #(
    .DIGIT_W    (4),
    .MAX_LEN    (16),
    .BASE_LEN   (3),
    .MAX_TRIES  (3),
    .TIMEOUT_CYC(10)
  ) dut (
    .clock(clock),
    .rst  (rst),
    .bus  (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drives one cycle of pulse inputs, then lets the DUT register the result.
  task automatic applyStimulus(input logic start, input logic [3:0] level, input logic [63:0] target,
                               input logic punch, input logic [3:0] digit,
                               input logic logout, input logic lvl_up);
    bus.start = start;
    if (start) begin
      bus.level_num  = level;
      bus.target_seq = target;
    end
    bus.punch        = punch;
    bus.punch_digit  = digit;
    bus.logout       = logout;
    bus.levelupdated = lvl_up;
    tick(1);
    bus.start        = 1'b0;
    bus.punch        = 1'b0;
    bus.logout       = 1'b0;
    bus.levelupdated = 1'b0;
  endtask

  task automatic start_round(input logic [3:0] level, input logic [63:0] target);
    applyStimulus(1'b1, level, target, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic do_punch(input logic [3:0] digit);
    applyStimulus(1'b0, 4'd0, 64'd0, 1'b1, digit, 1'b0, 1'b0);
  endtask

  task automatic level_up();
    applyStimulus(1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic do_logout();
    applyStimulus(1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 1'b1, 1'b0);
  endtask

  initial begin
    bus.auth_bit     = 1'b0;
    bus.logout       = 1'b0;
    bus.start        = 1'b0;
    bus.level_num    = 4'd0;
    bus.target_seq   = 64'd0;
    bus.punch        = 1'b0;
    bus.punch_digit  = 4'd0;
    bus.levelupdated = 1'b0;

    tick(2);
    checkOutput("reset_win",       bus.win,        0);
    checkOutput("reset_loose",     bus.loose,      0);
    checkOutput("reset_game_over", bus.game_over,  0);
    checkOutput("reset_busy",      bus.busy,       0);
    checkOutput("reset_entry_idx", bus.entry_idx,  0);
    checkOutput("reset_tries",     bus.tries_left, 3);
    rst = 1'b1;
    tick(1);
    bus.auth_bit = 1'b1;
    tick(1);
    checkOutput("armed_busy", bus.busy, 0);

    $display("[TB] level 1 win, target 3,7,1");
    start_round(4'd1, 64'h173);
    checkOutput("l1_busy_after_start", bus.busy,      1);
    checkOutput("l1_entry_after_start", bus.entry_idx, 0);
    bus.target_seq = 64'hFFF;
    do_punch(4'd3);
    checkOutput("l1_entry_1", bus.entry_idx, 1);
    do_punch(4'd7);
    checkOutput("l1_entry_2", bus.entry_idx, 2);
    checkOutput("l1_no_early_win", bus.win, 0);
    do_punch(4'd1);
    checkOutput("l1_win",       bus.win,        1);
    checkOutput("l1_entry_3",   bus.entry_idx,  3);
    checkOutput("l1_tries",     bus.tries_left, 3);
    checkOutput("l1_busy_done", bus.busy,       0);
    tick(1);
    checkOutput("l1_win_one_cycle", bus.win, 0);
    level_up();
    checkOutput("l1_tries_after_levelup", bus.tries_left, 3);

    $display("[TB] level 2 wrong digit, target 2,4,6,8");
    start_round(4'd2, 64'h8642);
    do_punch(4'd2);
    do_punch(4'd5);
    checkOutput("l2_loose",  bus.loose,      1);
    checkOutput("l2_entry",  bus.entry_idx,  1);
    checkOutput("l2_tries",  bus.tries_left, 2);
    checkOutput("l2_busy",   bus.busy,       0);
    do_punch(4'd6);
    checkOutput("l2_ignored_loose", bus.loose,      0);
    checkOutput("l2_ignored_win",   bus.win,        0);
    checkOutput("l2_ignored_entry", bus.entry_idx,  1);
    checkOutput("l2_ignored_tries", bus.tries_left, 2);

    $display("[TB] timeout after one correct punch");
    start_round(4'd1, 64'h555);
    do_punch(4'd5);
    checkOutput("to_entry_1", bus.entry_idx, 1);
    tick(9);
    checkOutput("to_no_loose_yet", bus.loose, 0);
    checkOutput("to_still_busy",   bus.busy,  1);
    tick(1);
    checkOutput("to_loose",      bus.loose,      1);
    checkOutput("to_tries",      bus.tries_left, 1);
    checkOutput("to_entry_kept", bus.entry_idx,  1);
    checkOutput("to_busy_clear", bus.busy,       0);

    $display("[TB] punch on the expiry edge");
    start_round(4'd1, 64'h555);
    tick(9);
    do_punch(4'd5);
    checkOutput("edge_no_loose", bus.loose,     0);
    checkOutput("edge_entry_1",  bus.entry_idx, 1);
    checkOutput("edge_busy",     bus.busy,      1);
    tick(9);
    do_punch(4'd5);
    checkOutput("reload_no_loose", bus.loose,     0);
    checkOutput("reload_entry_2",  bus.entry_idx, 2);
    do_punch(4'd5);
    checkOutput("edge_win",   bus.win,        1);
    checkOutput("edge_tries", bus.tries_left, 1);
    level_up();
    checkOutput("edge_tries_reload", bus.tries_left, 3);

    $display("[TB] three failed rounds");
    for (int r = 0; r < 3; r++) begin
      start_round(4'd1, 64'h173);
      do_punch(4'd9);
      checkOutput($sformatf("fail_round%0d_loose", r), bus.loose, 1);
      checkOutput($sformatf("fail_round%0d_tries", r), bus.tries_left, 32'(2 - r));
    end
    checkOutput("over_game_over", bus.game_over, 1);
    tick(1);
    checkOutput("over_held",       bus.game_over, 1);
    checkOutput("over_loose_drop", bus.loose,     0);
    start_round(4'd1, 64'h173);
    checkOutput("over_start_ignored_busy", bus.busy,      1'b0);
    checkOutput("over_start_ignored_go",   bus.game_over, 1);
    do_logout();
    checkOutput("logout_game_over", bus.game_over,  0);
    checkOutput("logout_tries",     bus.tries_left, 3);
    checkOutput("logout_busy",      bus.busy,       0);
    tick(1);

    $display("[TB] level 15 clamps to 16 digits");
    start_round(4'd15, 64'h0123456789ABCDEF);
    for (int i = 0; i < 15; i++) begin
      do_punch(4'(15 - i));
    end
    checkOutput("l15_entry_15", bus.entry_idx, 15);
    checkOutput("l15_no_win",   bus.win,       0);
    do_punch(4'd0);
    checkOutput("l15_win",      bus.win,       1);
    checkOutput("l15_entry_16", bus.entry_idx, 16);
    level_up();

    $display("[TB] level 0 uses length 3");
    start_round(4'd0, 64'h173);
    do_punch(4'd3);
    do_punch(4'd7);
    checkOutput("l0_no_win",  bus.win,  0);
    checkOutput("l0_busy",    bus.busy, 1);
    do_punch(4'd1);
    checkOutput("l0_win",     bus.win,       1);
    checkOutput("l0_entry_3", bus.entry_idx, 3);
    level_up();

    $display("[TB] async reset mid-entry");
    start_round(4'd1, 64'h173);
    do_punch(4'd4);
    checkOutput("pre_reset_tries", bus.tries_left, 2);
    start_round(4'd1, 64'h173);
    do_punch(4'd3);
    checkOutput("pre_reset_entry", bus.entry_idx, 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_busy",      bus.busy,       0);
    checkOutput("async_entry",     bus.entry_idx,  0);
    checkOutput("async_tries",     bus.tries_left, 3);
    checkOutput("async_game_over", bus.game_over,  0);
    #1;
    rst = 1'b1;
    tick(1);

    $display("[TB] logout mid-entry beats a winning punch");
    start_round(4'd1, 64'h173);
    do_punch(4'd3);
    do_punch(4'd7);
    checkOutput("lo_entry_2", bus.entry_idx, 2);
    applyStimulus(1'b0, 4'd0, 64'd0, 1'b1, 4'd1, 1'b1, 1'b0);
    checkOutput("lo_win",   bus.win,        0);
    checkOutput("lo_loose", bus.loose,      0);
    checkOutput("lo_busy",  bus.busy,       0);
    checkOutput("lo_entry", bus.entry_idx,  0);
    checkOutput("lo_tries", bus.tries_left, 3);
    tick(1);
    checkOutput("lo_win_after", bus.win, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule
